child_resp_collector: RTL and testbench

//  Return path of the root->child instance fan-out: gathers response beats from
//  NUM_CHILDREN child instances and merges them onto one upstream channel to the parent.
//  - Arbitration: round-robin.
//  - Buffering: FIFO of FIFO_DEPTH entries.
//  - Each upstream beat is tagged with the index of the child that produced it.

---
 rtl/child_resp_collector_if.sv | 35 +++
 rtl/child_resp_collector.sv | 114 +++++++++++
 tb/tb_child_resp_collector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/child_resp_collector_if.sv
// Child-to-parent response channel bundle for child_resp_collector.
// up_par exists only when COLLECTOR_PARITY_EN is defined.
interface child_resp_collector_if #(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 16,
    parameter int IDX_W        = $clog2(NUM_CHILDREN)
);
    logic [NUM_CHILDREN-1:0]        child_valid;
    logic [NUM_CHILDREN*DATA_W-1:0] child_data;
    logic [NUM_CHILDREN-1:0]        child_ready;
    logic                           up_valid;
    logic [DATA_W-1:0]              up_data;
    logic [IDX_W-1:0]               up_idx;
    logic                           up_ready;
`ifdef COLLECTOR_PARITY_EN
    logic                           up_par;
`endif

    // Master drives child beats and upstream ready; slave is the collector.
    modport master (
        output child_valid, child_data, up_ready,
        input  child_ready, up_valid, up_data, up_idx
`ifdef COLLECTOR_PARITY_EN
        , input up_par
`endif
    );

    modport slave (
        input  child_valid, child_data, up_ready,
        output child_ready, up_valid, up_data, up_idx
`ifdef COLLECTOR_PARITY_EN
        , output up_par
`endif
    );
endinterface

// File: rtl/child_resp_collector.sv
// Round-robin merge of NUM_CHILDREN response channels into one index-tagged FIFO upstream.
// Optional macro COLLECTOR_PARITY_EN adds a stored parity bit per beat (up_par).
module child_resp_collector #(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    child_resp_collector_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   beat_total
);
    localparam int IDX_W = $clog2(NUM_CHILDREN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef COLLECTOR_PARITY_EN
    localparam int ENTRY_W = IDX_W + DATA_W + 1;
`else
    localparam int ENTRY_W = IDX_W + DATA_W;
`endif

    logic [IDX_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand;
    logic               full;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;

    assign full = (count == CNT_W'(FIFO_DEPTH));

    // The wider cand_sum keeps the modulo correct for non-power-of-two child counts.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_CHILDREN))
                cand_sum = cand_sum - (IDX_W+1)'(NUM_CHILDREN);
            cand = cand_sum[IDX_W-1:0];
            if (!grant_any && bus.child_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (grant_idx == IDX_W'(i))
                grant_data = bus.child_data[i*DATA_W +: DATA_W];
        end
    end

    assign push = grant_any && !full && !rst;
    assign pop  = bus.up_valid && bus.up_ready;

    assign bus.child_ready = push ? ({{(NUM_CHILDREN-1){1'b0}}, 1'b1} << grant_idx)
                                  : '0;

`ifdef COLLECTOR_PARITY_EN
    assign push_entry = {^{grant_idx, grant_data}, grant_idx, grant_data};
`else
    assign push_entry = {grant_idx, grant_data};
`endif

    // Storage is left unreset; every reader is masked by the registered occupancy.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_total <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                beat_total <= beat_total + 32'd1;
                rr_ptr     <= (grant_idx == IDX_W'(NUM_CHILDREN-1)) ? '0
                                                                    : grant_idx + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    assign head         = mem[rd_ptr];
    assign fifo_count   = count;
    assign bus.up_valid = (count != '0);
    assign bus.up_data  = bus.up_valid ? head[DATA_W-1:0] : '0;
    assign bus.up_idx   = bus.up_valid ? head[DATA_W +: IDX_W] : '0;
`ifdef COLLECTOR_PARITY_EN
    assign bus.up_par   = bus.up_valid ? head[ENTRY_W-1] : 1'b0;
`endif
endmodule

// File: tb/tb_child_resp_collector.sv
// Directed bench for child_resp_collector: reset, round robin, skip/wrap, full, steady state, mid reset.
// Parity checks are compiled in when COLLECTOR_PARITY_EN is defined.
module tb_child_resp_collector;
    localparam int NUM_CHILDREN = 5;
    localparam int DATA_W       = 16;
    localparam int FIFO_DEPTH   = 4;
    localparam int IDX_W        = $clog2(NUM_CHILDREN);

    logic        clk;
    logic        rst;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [31:0] beat_total;
    int          n_checks;
    int          n_fail;

    child_resp_collector_if #(
        .NUM_CHILDREN(NUM_CHILDREN),
        .DATA_W(DATA_W),
        .IDX_W(IDX_W)
    ) bus ();

    child_resp_collector #(
        .NUM_CHILDREN(NUM_CHILDREN),
        .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fifo_count(fifo_count),
        .beat_total(beat_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_parity(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data,
                                input logic valid);
`ifdef COLLECTOR_PARITY_EN
        check_output("up_par", 32'(bus.up_par), valid ? 32'(^{idx, data}) : 32'd0);
`endif
    endtask

    task automatic apply_stimulus(input logic [NUM_CHILDREN-1:0] valid, input logic ready);
        bus.child_valid = valid;
        bus.up_ready    = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int i = 0; i < NUM_CHILDREN; i++)
            bus.child_data[i*DATA_W +: DATA_W] = 16'hA000 + 16'(i);
        apply_stimulus(5'b11111, 1'b0);
        #1;

        // Reset holds everything quiet even with all children valid.
        check_output("rst_child_ready", 32'(bus.child_ready), 32'd0);
        check_output("rst_up_valid", 32'(bus.up_valid), 32'd0);
        check_output("rst_fifo_count", 32'(fifo_count), 32'd0);
        check_output("rst_beat_total", beat_total, 32'd0);
        check_output("rst_up_data", 32'(bus.up_data), 32'd0);
        check_output("rst_up_idx", 32'(bus.up_idx), 32'd0);
        check_parity('0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post_rst_grant", 32'(bus.child_ready), 32'b00001);

        // Round robin with all children valid and upstream always ready.
        apply_stimulus(5'b11111, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_output("rr_child_ready", 32'(bus.child_ready), 32'(5'b00001 << (k % 5)));
            check_output("rr_up_idx", 32'(bus.up_idx), 32'((k - 1) % 5));
            check_output("rr_up_data", 32'(bus.up_data), 32'(16'hA000 + 16'((k - 1) % 5)));
            check_output("rr_fifo_count", 32'(fifo_count), 32'd1);
            check_parity(IDX_W'((k - 1) % 5), 16'hA000 + 16'((k - 1) % 5), 1'b1);
        end
        check_output("rr_beat_total", beat_total, 32'd7);

        // Skip and wrap: bring rr_ptr to 4, then only children 1 and 3 request.
        apply_stimulus(5'b01000, 1'b1);
        check_output("skip_grant3", 32'(bus.child_ready), 32'b01000);
        tick();
        apply_stimulus(5'b01010, 1'b1);
        check_output("wrap_grant1", 32'(bus.child_ready), 32'b00010);
        check_output("wrap_head3", 32'(bus.up_idx), 32'd3);
        tick();
        check_output("skip_grant3b", 32'(bus.child_ready), 32'b01000);
        check_output("skip_head1", 32'(bus.up_idx), 32'd1);
        tick();
        check_output("wrap_grant1b", 32'(bus.child_ready), 32'b00010);
        tick();
        check_output("skip_head1b", 32'(bus.up_idx), 32'd1);
        check_output("skip_beat_total", beat_total, 32'd11);

        // Full / backpressure from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(5'b11111, 1'b0);
        check_output("rst2_child_ready", 32'(bus.child_ready), 32'd0);
        check_output("rst2_fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("full_first_grant", 32'(bus.child_ready), 32'b00001);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check_output("full_fill_count", 32'(fifo_count), 32'(j));
            check_output("full_head_idx", 32'(bus.up_idx), 32'd0);
            check_output("full_head_data", 32'(bus.up_data), 32'h0000A000);
        end
        check_output("full_child_ready", 32'(bus.child_ready), 32'd0);
        check_output("full_beat_total", beat_total, 32'd4);
        apply_stimulus(5'b11111, 1'b1);
        check_output("full_pop_no_grant", 32'(bus.child_ready), 32'd0);
        tick();
        apply_stimulus(5'b11111, 1'b0);
        check_output("after_pop_count", 32'(fifo_count), 32'd3);
        check_output("after_pop_head", 32'(bus.up_idx), 32'd1);
        check_output("after_pop_grant4", 32'(bus.child_ready), 32'b10000);
        tick();
        check_output("refull_count", 32'(fifo_count), 32'd4);
        check_output("refull_beat_total", beat_total, 32'd5);

        // Drain in order 1,2,3,4.
        apply_stimulus(5'b00000, 1'b1);
        for (int j = 2; j <= 4; j++) begin
            tick();
            check_output("drain_head_idx", 32'(bus.up_idx), 32'(j));
        end
        tick();
        check_output("drain_up_valid", 32'(bus.up_valid), 32'd0);
        check_output("drain_up_data", 32'(bus.up_data), 32'd0);

        // Push+pop steady state with child 2 only.
        bus.child_data[2*DATA_W +: DATA_W] = 16'h1234;
        apply_stimulus(5'b00100, 1'b1);
        check_output("steady_grant2", 32'(bus.child_ready), 32'b00100);
        for (int n = 1; n <= 3; n++) begin
            tick();
            check_output("steady_count", 32'(fifo_count), 32'd1);
            check_output("steady_idx", 32'(bus.up_idx), 32'd2);
            check_output("steady_data", 32'(bus.up_data), 32'h00001234);
            check_output("steady_beat_total", beat_total, 32'(5 + n));
            check_parity(IDX_W'(2), 16'h1234, 1'b1);
        end

        // Build occupancy 3, then reset mid-operation.
        apply_stimulus(5'b00100, 1'b0);
        tick();
        tick();
        check_output("mid_count3", 32'(fifo_count), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(5'b11111, 1'b0);
        check_output("mid_rst_up_valid", 32'(bus.up_valid), 32'd0);
        check_output("mid_rst_count", 32'(fifo_count), 32'd0);
        check_output("mid_rst_beat_total", beat_total, 32'd0);
        check_output("mid_rst_up_data", 32'(bus.up_data), 32'd0);
        check_output("mid_rst_up_idx", 32'(bus.up_idx), 32'd0);
        check_output("mid_rst_child_ready", 32'(bus.child_ready), 32'd0);
        check_parity('0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("mid_rel_grant0", 32'(bus.child_ready), 32'b00001);
        check_output("mid_rel_up_valid", 32'(bus.up_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
